// File: rtl/xor_share_arbiter_pkg.sv
// Shared definitions for the XOR-sharing arbiter: FSM state type and counter width.
package xor_share_arbiter_pkg;

   // Encoding 2'd3 is unused; the FSM recovers from it to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   localparam int TXN_CNT_W = 16;

endpackage

// File: rtl/xor_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]  rr_ptr,
   output logic [N_REQ-1:0] grant_onehot,
   output logic [ID_W-1:0]  grant_idx,
   output logic             any_valid
);

   localparam int unsigned N = N_REQ;

   // Scan from rr_ptr upward modulo N_REQ and keep the first hit.
   always_comb begin
      logic              found;
      int unsigned       idx;
      logic [ID_W-1:0]   idx_w;
      grant_onehot = '0;
      grant_idx    = '0;
      found        = 1'b0;
      idx          = 0;
      idx_w        = '0;
      for (int unsigned off = 0; off < N; off++) begin
         idx   = (32'(rr_ptr) + off) % N;
         idx_w = ID_W'(idx);
         if (!found && req_valid[idx_w]) begin
            found               = 1'b1;
            grant_idx           = idx_w;
            grant_onehot[idx_w] = 1'b1;
         end
      end
   end

   assign any_valid = |req_valid;

endmodule

// File: rtl/xor_share_arbiter_xor_gate.sv
// Vector XOR datapath stage shared between requesters; purely combinational.
module xor_gate #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   assign y = a ^ b;

endmodule

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter sharing one registered XOR stage between N_REQ requesters.
// Optional feature: define XOR_ARB_PARITY_EN to add the registered rsp_parity output.
module xor_share_arbiter
   import xor_share_arbiter_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_a,
   input  logic [N_REQ*DATA_W-1:0] req_b,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_W-1:0]       rsp_data,
   output logic [ID_W-1:0]         rsp_id,
   output logic [TXN_CNT_W-1:0]    txn_cnt
`ifdef XOR_ARB_PARITY_EN
   ,
   output logic                    rsp_parity
`endif
);

   arb_state_e        state, state_nxt;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   g_lat;
   logic [DATA_W-1:0] a_lat, b_lat;
   logic [DATA_W-1:0] sel_a, sel_b;
   logic [DATA_W-1:0] xor_y;
   logic [N_REQ-1:0]  grant_onehot;
   logic [ID_W-1:0]   grant_idx;
   logic              any_valid;

   rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req_valid    (req_valid),
      .rr_ptr       (rr_ptr),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .any_valid    (any_valid)
   );

   xor_gate #(.W(DATA_W)) u_xor (
      .a (a_lat),
      .b (b_lat),
      .y (xor_y)
   );

   // Operand mux for the requester currently being granted.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_a = req_a[i*DATA_W +: DATA_W];
            sel_b = req_b[i*DATA_W +: DATA_W];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and grant decode; req_ready is gated by rst_n so it reads 0 while reset is held.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         ST_IDLE: begin
            if (any_valid && rst_n) begin
               req_ready = grant_onehot;
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Operand latch, result register, response handshake and round-robin pointer update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_lat      <= '0;
         b_lat      <= '0;
         g_lat      <= '0;
         rr_ptr     <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_id     <= '0;
         txn_cnt    <= '0;
`ifdef XOR_ARB_PARITY_EN
         rsp_parity <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_valid) begin
                  a_lat <= sel_a;
                  b_lat <= sel_b;
                  g_lat <= grant_idx;
               end
            end
            ST_BUSY: begin
               rsp_data   <= xor_y;
               rsp_id     <= g_lat;
               rsp_valid  <= 1'b1;
`ifdef XOR_ARB_PARITY_EN
               rsp_parity <= ^xor_y;
`endif
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  txn_cnt   <= txn_cnt + 1'b1;
                  rr_ptr    <= (g_lat == ID_W'(N_REQ-1)) ? '0 : g_lat + 1'b1;
               end
            end
            default: rsp_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Randomised self-checking bench for xor_share_arbiter against a round-robin reference model.
// Build with or without XOR_ARB_PARITY_EN; the parity scenario is compiled only when defined.
module tb_xor_share_arbiter;

   localparam int N_REQ  = 4;
   localparam int DATA_W = 8;
   localparam int ID_W   = 2;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_a, req_b;
   logic [N_REQ-1:0]        req_ready;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [DATA_W-1:0]       rsp_data;
   logic [ID_W-1:0]         rsp_id;
   logic [15:0]             txn_cnt;
`ifdef XOR_ARB_PARITY_EN
   logic                    rsp_parity;
`endif

   xor_share_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .txn_cnt    (txn_cnt)
`ifdef XOR_ARB_PARITY_EN
      ,
      .rsp_parity (rsp_parity)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state: next-highest-priority requester and completed count.
   int m_ptr = 0;
   int m_cnt = 0;

   // Observations captured by drive_txn for the scenario tasks to judge.
   logic [N_REQ-1:0]  obs_gnt, obs_busy_ready, obs_resp_ready;
   logic              obs_busy_valid, obs_valid, obs_stable, obs_after_valid, obs_par;
   logic [DATA_W-1:0] obs_data;
   logic [ID_W-1:0]   obs_id;
   logic [15:0]       obs_cnt;

   function automatic int model_pick(input logic [N_REQ-1:0] v);
      for (int k = 0; k < N_REQ; k++)
         if (v[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
      return 0;
   endfunction

   function automatic void model_commit(input int g);
      m_ptr = (g + 1) % N_REQ;
      m_cnt = (m_cnt + 1) % 65536;
   endfunction

   // Runs one request through accept, result and handshake, starting just after a rising edge in IDLE.
   task automatic drive_txn(input logic [N_REQ-1:0] v, input logic [31:0] a, input logic [31:0] b,
                            input int stall, input bit keep);
      req_valid = v;
      req_a     = a;
      req_b     = b;
      rsp_ready = (stall == 0);
      @(negedge clk);
      obs_gnt = req_ready;
      @(posedge clk); #1;
      if (!keep) req_valid = '0;
      @(negedge clk);
      obs_busy_ready = req_ready;
      obs_busy_valid = rsp_valid;
      @(negedge clk);
      obs_valid      = rsp_valid;
      obs_data       = rsp_data;
      obs_id         = rsp_id;
      obs_resp_ready = req_ready;
`ifdef XOR_ARB_PARITY_EN
      obs_par        = rsp_parity;
`else
      obs_par        = 1'b0;
`endif
      obs_stable = 1'b1;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== obs_data || rsp_id !== obs_id || req_ready !== '0)
            obs_stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      obs_after_valid = rsp_valid;
      obs_cnt         = txn_cnt;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      m_ptr = 0;
      m_cnt = 0;
   endtask

   task automatic test_reset();
      int g;
      logic [31:0] a, b;
      rst_n = 1'b0; req_valid = 4'b1111; req_a = '1; req_b = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); end
      total++; if (rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data got=%h want=00", rsp_data); end
      total++; if (rsp_id !== '0) begin bad++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
      total++; if (txn_cnt !== '0) begin bad++; $display("FAIL reset_txn_cnt got=%h want=0000", txn_cnt); end
      total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
      // Reset in the middle of a response must clear it without waiting for an edge.
      rst_n = 1'b1; req_valid = 4'b0100; req_a = 32'h00AB_0000; req_b = 32'h0011_0000;
      @(posedge clk); #1 req_valid = '0;
      @(posedge clk); #1;
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_rsp_valid got=%0b want=1", rsp_valid); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0) begin
         bad++; $display("FAIL async_reset got=v%0b d%h id%0d want=v0 d00 id0", rsp_valid, rsp_data, rsp_id);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      m_ptr = 0; m_cnt = 0;
      a = $urandom(); b = $urandom();
      g = model_pick(4'b1111);
      drive_txn(4'b1111, a, b, 0, 1'b0);
      model_commit(g);
      total++; if (obs_gnt !== 4'b0001) begin bad++; $display("FAIL first_grant got=%b want=0001", obs_gnt); end
      total++; if (obs_data !== (a[7:0] ^ b[7:0])) begin bad++; $display("FAIL first_data got=%h want=%h", obs_data, a[7:0] ^ b[7:0]); end
      total++; if (obs_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL first_cnt got=%0d want=%0d", obs_cnt, m_cnt); end
   endtask

   task automatic test_single();
      int g;
      g = model_pick(4'b0100);
      drive_txn(4'b0100, 32'h00A5_0000, 32'h000F_0000, 0, 1'b0);
      model_commit(g);
      total++; if (obs_gnt !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b want=0100", obs_gnt); end
      total++; if (obs_busy_ready !== '0 || obs_busy_valid !== 1'b0) begin
         bad++; $display("FAIL single_busy got=rdy%b v%0b want=rdy0000 v0", obs_busy_ready, obs_busy_valid);
      end
      total++; if (obs_valid !== 1'b1 || obs_data !== 8'hAA || obs_id !== 2'd2) begin
         bad++; $display("FAIL single_rsp got=v%0b d%h id%0d want=v1 dAA id2", obs_valid, obs_data, obs_id);
      end
      total++; if (obs_cnt !== 16'(m_cnt) || obs_after_valid !== 1'b0) begin
         bad++; $display("FAIL single_done got=cnt%0d v%0b want=cnt%0d v0", obs_cnt, obs_after_valid, m_cnt);
      end
   endtask

   task automatic test_round_robin();
      int g;
      logic [31:0] a, b;
      apply_reset();
      for (int n = 0; n < 5; n++) begin
         a = $urandom(); b = $urandom();
         g = model_pick(4'b1111);
         drive_txn(4'b1111, a, b, 0, 1'b1);
         model_commit(g);
         total++; if (obs_gnt !== 4'(1 << (n % 4)) || obs_id !== 2'(n % 4)) begin
            bad++; $display("FAIL rr_grant[%0d] got=%b id%0d want=%b id%0d", n, obs_gnt, obs_id, 4'(1 << (n % 4)), n % 4);
         end
         total++; if (obs_data !== (a[g*8 +: 8] ^ b[g*8 +: 8])) begin
            bad++; $display("FAIL rr_data[%0d] got=%h want=%h", n, obs_data, a[g*8 +: 8] ^ b[g*8 +: 8]);
         end
      end
   endtask

   task automatic test_backpressure();
      int g;
      logic [31:0] a, b;
      a = $urandom(); b = $urandom();
      g = model_pick(4'b1010);
      drive_txn(4'b1010, a, b, 5, 1'b0);
      model_commit(g);
      total++; if (obs_stable !== 1'b1) begin bad++; $display("FAIL bp_stable got=%0b want=1", obs_stable); end
      total++; if (obs_resp_ready !== '0) begin bad++; $display("FAIL bp_req_ready got=%b want=0000", obs_resp_ready); end
      total++; if (obs_data !== (a[g*8 +: 8] ^ b[g*8 +: 8]) || obs_id !== 2'(g)) begin
         bad++; $display("FAIL bp_rsp got=d%h id%0d want=d%h id%0d", obs_data, obs_id, a[g*8 +: 8] ^ b[g*8 +: 8], g);
      end
      total++; if (obs_after_valid !== 1'b0 || obs_cnt !== 16'(m_cnt)) begin
         bad++; $display("FAIL bp_accept got=v%0b cnt%0d want=v0 cnt%0d", obs_after_valid, obs_cnt, m_cnt);
      end
   endtask

   task automatic test_wrap();
      int g;
      force dut.txn_cnt = 16'hFFFF;
      #1 release dut.txn_cnt;
      m_cnt = 16'hFFFF;
      g = model_pick(4'b1000);
      drive_txn(4'b1000, $urandom(), $urandom(), 0, 1'b0);
      model_commit(g);
      total++; if (obs_cnt !== 16'h0000) begin bad++; $display("FAIL cnt_wrap got=%h want=0000", obs_cnt); end
      total++; if (obs_gnt !== 4'b1000) begin bad++; $display("FAIL wrap_grant3 got=%b want=1000", obs_gnt); end
      g = model_pick(4'b1111);
      drive_txn(4'b1111, $urandom(), $urandom(), 0, 1'b0);
      model_commit(g);
      total++; if (obs_gnt !== 4'b0001) begin bad++; $display("FAIL ptr_wrap got=%b want=0001", obs_gnt); end
   endtask

   task automatic test_parity();
`ifdef XOR_ARB_PARITY_EN
      drive_txn(4'b0001, 32'h0000_0001, 32'h0000_0002, 0, 1'b0);
      model_commit(0);
      total++; if (obs_data !== 8'h03 || obs_par !== 1'b0) begin
         bad++; $display("FAIL parity_even got=d%h p%0b want=d03 p0", obs_data, obs_par);
      end
      drive_txn(4'b0001, 32'h0000_0001, 32'h0000_0000, 0, 1'b0);
      model_commit(0);
      total++; if (obs_data !== 8'h01 || obs_par !== 1'b1) begin
         bad++; $display("FAIL parity_odd got=d%h p%0b want=d01 p1", obs_data, obs_par);
      end
`endif
   endtask

   task automatic test_random();
      int g, stall;
      bit keep;
      logic [N_REQ-1:0] v;
      logic [31:0] a, b;
      logic [7:0] exp_d;
      req_valid = '0; rsp_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         total++; if (req_ready !== '0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL idle_quiet got=rdy%b v%0b want=rdy0000 v0", req_ready, rsp_valid);
         end
      end
      @(posedge clk); #1;
      for (int n = 0; n < 40; n++) begin
         v = 4'($urandom_range(1, 15));
         a = $urandom(); b = $urandom();
         stall = $urandom_range(0, 3);
         keep = 1'($urandom_range(0, 1));
         g = model_pick(v);
         exp_d = a[g*8 +: 8] ^ b[g*8 +: 8];
         drive_txn(v, a, b, stall, keep);
         model_commit(g);
         total++; if (obs_gnt !== 4'(1 << g) || obs_busy_ready !== '0) begin
            bad++; $display("FAIL rand_grant[%0d] v=%b got=%b busy%b want=%b busy0000", n, v, obs_gnt, obs_busy_ready, 4'(1 << g));
         end
         total++; if (obs_valid !== 1'b1 || obs_data !== exp_d || obs_id !== 2'(g) || obs_stable !== 1'b1) begin
            bad++; $display("FAIL rand_rsp[%0d] got=v%0b d%h id%0d st%0b want=v1 d%h id%0d st1", n, obs_valid, obs_data, obs_id, obs_stable, exp_d, g);
         end
         total++; if (obs_cnt !== 16'(m_cnt) || obs_after_valid !== 1'b0) begin
            bad++; $display("FAIL rand_done[%0d] got=cnt%0d v%0b want=cnt%0d v0", n, obs_cnt, obs_after_valid, m_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_parity();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
